// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO: Gray/binary helpers, FWFT state codes
// and output-mode selectors.
package fifo_pkg;

  localparam int GW = 32;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_VALID = 2'd2;

  localparam int MODE_STD  = 0;
  localparam int MODE_FWFT = 1;

  // Callers zero-extend narrower pointers to GW bits and truncate the result.
  function automatic logic [GW-1:0] bin2gray(input logic [GW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
    logic [GW-1:0] b;
    b = '0;
    for (int i = 0; i < GW; i++) b[i] = ^(g >> i);
    return b;
  endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter; each binary bit is the XOR of all
// Gray bits at or above it.
module fifo_gray2bin #(
  parameter int W = 4
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  always_comb begin
    bin_o = '0;
    for (int i = 0; i < W; i++) bin_o[i] = ^(gray_i >> i);
  end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller of the async FIFO: read pointers, empty/level flags,
// sticky underflow, and standard or first-word-fall-through output staging.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR   = 3,
  parameter int DW     = 8,
  parameter int AE_LVL = 1,
  parameter int FWFT   = 0
) (
  input  logic            rclk,
  input  logic            rrst,
  input  logic            rinc,
  input  logic [ADDR:0]   rq2_wptr,
  input  logic [DW-1:0]   rmem_rdata,
  output logic [ADDR-1:0] raddr,
  output logic            ren,
  output logic [ADDR:0]   rptr,
  output logic [DW-1:0]   rdata,
  output logic            rvalid,
  output logic            rempty,
  output logic            ralmost_empty,
  output logic [ADDR:0]   rlevel,
  output logic            runderflow
);

  localparam int PW = ADDR + 1;
  localparam logic [PW:0] AE_THR = (PW+1)'(AE_LVL);

  logic [ADDR:0]   wq_q, rbin_q, rbin_d, rptr_q, wbin_d, level_d, rlevel_q;
  logic [1:0]      state_q, state_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            rvalid_q, rvalid_d, unf_q, ae_q;
  logic            mem_empty, pop, empty_vis, occ;

  // Level is computed from next-state values so the registered flag matches
  // the registered pointers and never over-reports.
  fifo_gray2bin #(.W(PW)) u_wbin (
    .gray_i (rq2_wptr),
    .bin_o  (wbin_d)
  );

  assign mem_empty = (wq_q == rptr_q);

  always_comb begin
    pop      = 1'b0;
    state_d  = state_q;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    if (FWFT == MODE_STD) begin
      pop      = rinc & ~mem_empty;
      rvalid_d = pop;
      if (rvalid_q) rdata_d = rmem_rdata;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (!mem_empty) begin
            pop     = 1'b1;
            state_d = ST_FETCH;
          end
        end
        ST_FETCH: begin
          rdata_d = rmem_rdata;
          state_d = ST_VALID;
        end
        ST_VALID: begin
          if (rinc) begin
            if (!mem_empty) begin
              pop     = 1'b1;
              state_d = ST_FETCH;
            end else begin
              state_d = ST_EMPTY;
            end
          end
        end
        default: state_d = ST_EMPTY;
      endcase
      rvalid_d = (state_d == ST_VALID);
    end
  end

  assign rbin_d    = pop ? rbin_q + 1'b1 : rbin_q;
  assign occ       = (FWFT == MODE_FWFT) && (state_d != ST_EMPTY);
  assign level_d   = wbin_d - rbin_d + {{ADDR{1'b0}}, occ};
  assign empty_vis = (FWFT == MODE_STD) ? mem_empty : ~rvalid_q;

  always_ff @(posedge rclk) begin
    if (rrst) begin
      wq_q     <= '0;
      rbin_q   <= '0;
      rptr_q   <= '0;
      state_q  <= ST_EMPTY;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rlevel_q <= '0;
      ae_q     <= 1'b1;
      unf_q    <= 1'b0;
    end else begin
      wq_q     <= rq2_wptr;
      rbin_q   <= rbin_d;
      rptr_q   <= PW'(bin2gray(GW'(rbin_d)));
      state_q  <= state_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rlevel_q <= level_d;
      ae_q     <= ({1'b0, level_d} <= AE_THR);
      if (rinc && empty_vis) unf_q <= 1'b1;
    end
  end

  // In standard mode the memory word is passed straight through while valid;
  // rdata_q keeps it afterwards.
  assign rdata         = ((FWFT == MODE_STD) && rvalid_q) ? rmem_rdata : rdata_q;
  assign raddr         = rbin_q[ADDR-1:0];
  assign ren           = pop;
  assign rptr          = rptr_q;
  assign rvalid        = rvalid_q;
  assign rempty        = empty_vis;
  assign ralmost_empty = ae_q;
  assign rlevel        = rlevel_q;
  assign runderflow    = unf_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: a standard-mode instance (AE_LVL=2) and an FWFT
// instance (AE_LVL=1), each fed by its own synchronous-read memory model.
module tb_fifo_rd_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rrst, rinc, ren, rvalid, rempty, rae, runf;
  logic [3:0] rq2 [2];
  logic [7:0] rmem [2];
  logic [2:0] raddr [2];
  logic [3:0] rptr [2];
  logic [3:0] rlevel [2];
  logic [7:0] rdata [2];
  logic [7:0] mem [2][8];
  logic [7:0] hist [2][16];

  fifo_rd_ctrl #(.ADDR(3), .DW(8), .AE_LVL(2), .FWFT(0)) u_std (
    .rclk(clk), .rrst(rrst[0]), .rinc(rinc[0]), .rq2_wptr(rq2[0]), .rmem_rdata(rmem[0]),
    .raddr(raddr[0]), .ren(ren[0]), .rptr(rptr[0]), .rdata(rdata[0]), .rvalid(rvalid[0]),
    .rempty(rempty[0]), .ralmost_empty(rae[0]), .rlevel(rlevel[0]), .runderflow(runf[0])
  );

  fifo_rd_ctrl #(.ADDR(3), .DW(8), .AE_LVL(1), .FWFT(1)) u_fwft (
    .rclk(clk), .rrst(rrst[1]), .rinc(rinc[1]), .rq2_wptr(rq2[1]), .rmem_rdata(rmem[1]),
    .raddr(raddr[1]), .ren(ren[1]), .rptr(rptr[1]), .rdata(rdata[1]), .rvalid(rvalid[1]),
    .rempty(rempty[1]), .ralmost_empty(rae[1]), .rlevel(rlevel[1]), .runderflow(runf[1])
  );

  always @(posedge clk) begin
    if (ren[0]) rmem[0] <= mem[0][raddr[0]];
    if (ren[1]) rmem[1] <= mem[1][raddr[1]];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [3:0] gray4(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  // Behavioural model: word counts, a history of written words, and the
  // position of the head word in the FWFT output stage (0 none, 1 fetching, 2 held).
  logic [3:0] m_wcnt [2], m_wq [2], m_rcnt [2], m_prev_rptr [2];
  logic [7:0] m_last [2], m_pend [2];
  int         m_phase [2];
  bit         m_unf [2], m_vld [2], m_was_rst [2];
  int         rd_pct [2], wr_pct [2];

  task automatic model_step(int d, bit rst, bit inc);
    bit avail, vis_empty;
    m_was_rst[d] = rst;
    if (rst) begin
      m_wq[d] = 0; m_rcnt[d] = 0; m_phase[d] = 0;
      m_last[d] = 0; m_unf[d] = 0; m_vld[d] = 0;
      return;
    end
    avail     = (m_wq[d] != m_rcnt[d]);
    vis_empty = (d == 0) ? !avail : (m_phase[d] != 2);
    if (inc && vis_empty) m_unf[d] = 1;
    m_vld[d] = 0;
    if (d == 0) begin
      if (inc && avail) begin
        m_last[d] = hist[d][m_rcnt[d]];
        m_rcnt[d] = m_rcnt[d] + 1;
        m_vld[d]  = 1;
      end
    end else begin
      case (m_phase[d])
        0: if (avail) begin
             m_pend[d] = hist[d][m_rcnt[d]]; m_rcnt[d] = m_rcnt[d] + 1; m_phase[d] = 1;
           end
        1: begin m_last[d] = m_pend[d]; m_phase[d] = 2; end
        default: if (inc) begin
          if (avail) begin
            m_pend[d] = hist[d][m_rcnt[d]]; m_rcnt[d] = m_rcnt[d] + 1; m_phase[d] = 1;
          end else m_phase[d] = 0;
        end
      endcase
    end
    m_wq[d] = m_wcnt[d];
  endtask

  task automatic check_model(int d);
    int lvl;
    bit e_empty, e_valid;
    lvl     = int'(4'(m_wq[d] - m_rcnt[d])) + ((d == 1 && m_phase[d] != 0) ? 1 : 0);
    e_empty = (d == 0) ? (m_wq[d] == m_rcnt[d]) : (m_phase[d] != 2);
    e_valid = (d == 0) ? m_vld[d] : (m_phase[d] == 2);
    chk($sformatf("rempty[%0d]", d), rempty[d], e_empty);
    chk($sformatf("rvalid[%0d]", d), rvalid[d], e_valid);
    chk($sformatf("rlevel[%0d]", d), rlevel[d], lvl);
    chk($sformatf("ralmost_empty[%0d]", d), rae[d], lvl <= ((d == 0) ? 2 : 1));
    chk($sformatf("runderflow[%0d]", d), runf[d], m_unf[d]);
    chk($sformatf("raddr[%0d]", d), raddr[d], m_rcnt[d] & 4'h7);
    chk($sformatf("rptr[%0d]", d), rptr[d], gray4(m_rcnt[d]));
    chk($sformatf("rdata[%0d]", d), rdata[d], m_last[d]);
    if (!m_was_rst[d] && rptr[d] != m_prev_rptr[d])
      chk($sformatf("rptr_onebit[%0d]", d), $countones(rptr[d] ^ m_prev_rptr[d]), 1);
    m_prev_rptr[d] = rptr[d];
  endtask

  task automatic drive_random(int d);
    bit rst, inc, wr;
    logic [7:0] dat;
    rst = ($urandom_range(0, 249) == 0);
    inc = ($urandom_range(0, 99) < rd_pct[d]);
    wr  = !rst && ($urandom_range(0, 99) < wr_pct[d]) && (4'(m_wcnt[d] - m_rcnt[d]) < 4'd8);
    if (rst) m_wcnt[d] = 0;
    if (wr) begin
      dat = 8'($urandom);
      mem[d][m_wcnt[d][2:0]] = dat;
      hist[d][m_wcnt[d]]     = dat;
      m_wcnt[d] = m_wcnt[d] + 1;
    end
    rrst[d] = rst;
    rinc[d] = inc;
    rq2[d]  = gray4(m_wcnt[d]);
    model_step(d, rst, inc);
  endtask

  typedef struct {
    bit rst; bit inc; logic [3:0] wg;
    bit e_empty; bit e_valid; logic [3:0] e_lvl; bit e_ae;
    logic [2:0] e_addr; logic [3:0] e_rptr; bit e_unf;
  } vec_t;

  vec_t tbl [10];
  int   pct_tab [4];

  initial begin
    //         rst   inc   wg     empty valid lvl   ae    addr  rptr   unf
    tbl[0] = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 4'd0, 1'b1, 3'd0, 4'h0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 4'd0, 1'b1, 3'd0, 4'h0, 1'b1};
    tbl[2] = '{1'b0, 1'b0, 4'h2, 1'b0, 1'b0, 4'd3, 1'b0, 3'd0, 4'h0, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 4'h2, 1'b0, 1'b1, 4'd2, 1'b1, 3'd1, 4'h1, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 4'h2, 1'b0, 1'b1, 4'd1, 1'b1, 3'd2, 4'h3, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 4'h2, 1'b1, 1'b1, 4'd0, 1'b1, 3'd3, 4'h2, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 4'h2, 1'b1, 1'b0, 4'd0, 1'b1, 3'd3, 4'h2, 1'b1};
    tbl[7] = '{1'b0, 1'b1, 4'h2, 1'b1, 1'b0, 4'd0, 1'b1, 3'd3, 4'h2, 1'b1};
    tbl[8] = '{1'b1, 1'b0, 4'h2, 1'b1, 1'b0, 4'd0, 1'b1, 3'd0, 4'h0, 1'b0};
    tbl[9] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'd0, 1'b1, 3'd0, 4'h0, 1'b0};
    pct_tab[0] = 10; pct_tab[1] = 50; pct_tab[2] = 90; pct_tab[3] = 100;

    rrst = 2'b11; rinc = 2'b00; rq2[0] = 4'h0; rq2[1] = 4'h0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 8; i++) mem[d][i] = 8'h00;
    @(negedge clk);
    @(negedge clk);

    // Standard-mode directed vectors: underflow, three pops, reset.
    for (int i = 0; i < 10; i++) begin
      rrst[0] = tbl[i].rst; rinc[0] = tbl[i].inc; rq2[0] = tbl[i].wg;
      @(negedge clk);
      chk($sformatf("v%0d.rempty", i), rempty[0], tbl[i].e_empty);
      chk($sformatf("v%0d.rvalid", i), rvalid[0], tbl[i].e_valid);
      chk($sformatf("v%0d.rlevel", i), rlevel[0], tbl[i].e_lvl);
      chk($sformatf("v%0d.ralmost_empty", i), rae[0], tbl[i].e_ae);
      chk($sformatf("v%0d.raddr", i), raddr[0], tbl[i].e_addr);
      chk($sformatf("v%0d.rptr", i), rptr[0], tbl[i].e_rptr);
      chk($sformatf("v%0d.runderflow", i), runf[0], tbl[i].e_unf);
    end
    rrst[0] = 1'b1; rinc[0] = 1'b0; rq2[0] = 4'h0;

    // FWFT: two words become visible, back-to-back read, then reset while VALID.
    mem[1][0] = 8'hA5; mem[1][1] = 8'h3C; mem[1][2] = 8'h77;
    rrst[1] = 1'b0; rinc[1] = 1'b0; rq2[1] = gray4(4'd2);
    @(negedge clk);
    chk("fw.e1.rlevel", rlevel[1], 2);  chk("fw.e1.rvalid", rvalid[1], 0);
    @(negedge clk);
    chk("fw.e2.rvalid", rvalid[1], 0);  chk("fw.e2.rptr", rptr[1], 4'b0001);
    chk("fw.e2.raddr", raddr[1], 1);    chk("fw.e2.rlevel", rlevel[1], 2);
    @(negedge clk);
    chk("fw.e3.rvalid", rvalid[1], 1);  chk("fw.e3.rdata", rdata[1], 8'hA5);
    chk("fw.e3.rempty", rempty[1], 0);  chk("fw.e3.rlevel", rlevel[1], 2);
    rinc[1] = 1'b1;
    @(negedge clk);
    chk("fw.e4.rvalid", rvalid[1], 0);  chk("fw.e4.rempty", rempty[1], 1);
    chk("fw.e4.rlevel", rlevel[1], 1);  chk("fw.e4.rdata", rdata[1], 8'hA5);
    @(negedge clk);
    chk("fw.e5.rvalid", rvalid[1], 1);  chk("fw.e5.rdata", rdata[1], 8'h3C);
    chk("fw.e5.rlevel", rlevel[1], 1);  chk("fw.e5.runderflow", runf[1], 1);
    @(negedge clk);
    chk("fw.e6.rvalid", rvalid[1], 0);  chk("fw.e6.rempty", rempty[1], 1);
    chk("fw.e6.rlevel", rlevel[1], 0);  chk("fw.e6.ralmost_empty", rae[1], 1);
    rinc[1] = 1'b0; rq2[1] = gray4(4'd3);
    @(negedge clk);
    chk("fw.e7.rlevel", rlevel[1], 1);
    @(negedge clk);
    @(negedge clk);
    chk("fw.e9.rvalid", rvalid[1], 1);  chk("fw.e9.rdata", rdata[1], 8'h77);
    rrst[1] = 1'b1; rq2[1] = 4'h0;
    @(negedge clk);
    chk("fw.rst.rvalid", rvalid[1], 0); chk("fw.rst.rempty", rempty[1], 1);
    chk("fw.rst.rptr", rptr[1], 0);     chk("fw.rst.runderflow", runf[1], 0);
    chk("fw.rst.rdata", rdata[1], 0);   chk("fw.rst.rlevel", rlevel[1], 0);
    rrst[1] = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("fw.idle.rvalid", rvalid[1], 0);
      chk("fw.idle.rempty", rempty[1], 1);
    end

    // Randomised traffic on both instances against the model.
    rrst = 2'b11; rinc = 2'b00; rq2[0] = 4'h0; rq2[1] = 4'h0;
    for (int d = 0; d < 2; d++) begin
      m_wcnt[d] = 0; m_prev_rptr[d] = 0; m_pend[d] = 0;
      model_step(d, 1'b1, 1'b0);
    end
    @(negedge clk);
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (cyc % 100 == 0)
        for (int d = 0; d < 2; d++) begin
          rd_pct[d] = pct_tab[$urandom_range(0, 3)];
          wr_pct[d] = pct_tab[$urandom_range(0, 3)];
        end
      for (int d = 0; d < 2; d++) begin
        check_model(d);
        drive_random(d);
      end
      @(negedge clk);
    end
    for (int d = 0; d < 2; d++) check_model(d);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
Parametrised read-side controller for the async FIFO, next generation of the read-pointer block. It keeps the binary and Gray read pointers, registers the synchronised write pointer, and computes empty, almost-empty, occupancy level and sticky underflow. It drives the synchronous-read FIFO memory and supports standard or first-word-fall-through (FWFT) output mode. It sits in the read clock domain between the 2-flop write-pointer synchroniser and the FIFO memory.

Parameters:
ADDR, 3, address width; depth = 2**ADDR
DW, 8, data width
AE_LVL, 1, almost-empty threshold in words (0..2**ADDR)
FWFT, 0, 0 = standard mode, 1 = first-word-fall-through

Ports:
rclk  in  1  read-domain clock
rrst  in  1  reset; synchronous, active-high
rinc  in  1  read request
rq2_wptr  in  ADDR+1  Gray write pointer, already 2-flop synchronised
rmem_rdata  in  DW  memory read data, valid 1 rclk after ren
raddr  out  ADDR  memory read address = rbin[ADDR-1:0]
ren  out  1  memory read enable
rptr  out  ADDR+1  registered Gray read pointer, to write-side synchroniser
rdata  out  DW  read data to consumer
rvalid  out  1  rdata valid
rempty  out  1  consumer-visible empty
ralmost_empty  out  1  rlevel <= AE_LVL
rlevel  out  ADDR+1  words available to consumer
runderflow  out  1  sticky underflow

Behaviour:
- Only rrst sampled high at posedge rclk resets. All state and outputs go to 0, except rempty=1 and ralmost_empty=1. Reset mid-operation discards any prefetched word.
- wq: rq2_wptr registered every cycle (one extra stage). wbin = gray2bin(wq).
- mem_empty = (wq == rptr), using full ADDR+1 bits so wrap is handled by the MSB.
- pop = memory read accepted. On pop: rbin <= rbin+1 (mod 2**(ADDR+1)) and rptr <= bin2gray(rbin+1) in the same edge. rptr is never combinational.
- ren = pop. raddr = current rbin, so the address is presented in the pop cycle.
- Standard mode (FWFT=0):
  - pop = rinc & !mem_empty.
  - rempty = mem_empty.
  - Next cycle: rdata <= rmem_data, rvalid=1 for 1 cycle. rdata holds otherwise.
- FWFT mode:
  - Output register plus FSM with states EMPTY, FETCH, VALID.
  - EMPTY: if !mem_empty, pop and go to FETCH.
  - FETCH: capture rmem_rdata into rdata and go to VALID.
  - VALID: on rinc, the word is consumed.
    - If !mem_empty, pop in the same cycle and go to FETCH. This gives back-to-back prefetch: 1 bubble cycle per word at full rate.
    - Otherwise go to EMPTY.
  - rvalid = (state==VALID). rempty = !rvalid. First-word latency after mem becomes non-empty: 2 rclk.
- rlevel, registered:
  - Standard mode: (wbin - rbin) mod 2**(ADDR+1).
  - FWFT mode: same term plus 1 if state is FETCH or VALID.
  - Range 0..2**ADDR. rlevel is pessimistic by the synchroniser latency and never over-reports.
- ralmost_empty = (rlevel <= AE_LVL), registered alongside rlevel.
- Underflow: rinc while rempty=1 does not move the pointers. runderflow sets on the next edge and stays set until rrst.
- Simultaneous write arrival and last read: empty is evaluated on the current registered wq. New data appears no earlier than the cycle after wq updates.
- Wrap: rbin rolls 2**(ADDR+1)-1 -> 0. rptr Gray sequence stays continuous, with 1 bit change per increment.

Decomposition:
- Package fifo_pkg:
  - functions gray2bin and bin2gray, parametrised by width
  - FWFT state encoding constants: ST_EMPTY=2'd0, ST_FETCH=2'd1, ST_VALID=2'd2
  - mode constants MODE_STD=0, MODE_FWFT=1
- One sub-module: fifo_gray2bin, a combinational XOR-prefix converter of width ADDR+1. It is reused by the write side for its level.

Test Plan:
1. Reset, then rinc=1 with rq2_wptr=0 -> rempty=1, ralmost_empty=1, rlevel=0, raddr and rptr stay 0, runderflow=1 the next cycle and stays 1 until rrst.
2. Standard mode, ADDR=3: rq2_wptr=Gray(3)=4'b0010, then 3 rinc pulses -> ren 3 times, raddr 0,1,2, rptr 0001, 0011, 0010, rvalid one cycle after each pop, rempty=1 after the third pop, rlevel 3 -> 0.
3. Wrap: write and read 20 words at ADDR=3 -> rbin crosses 15->0. Check rptr changes 1 bit per increment, rempty correct when wq == rptr = 4'b1110 (Gray 11).
4. FWFT mode: wq goes from 0 to Gray(2) -> rvalid rises 2 cycles after wq changes with rdata = word0. Then hold rinc=1 -> word1 valid 2 cycles later, then rempty=1. rlevel goes 2 -> 1 -> 0.
5. AE_LVL=2: fill level 4, then read down -> ralmost_empty=0 at levels 4 and 3, =1 at 2, 1, 0.
6. rrst asserted in FWFT state VALID with rvalid=1 -> next edge: rvalid=0, rempty=1, rptr=0, FSM in EMPTY, runderflow cleared.
